vtx_mem_txn_capture: RTL and testbench
======================================

VTX_MEM_TXN_CAPTURE -- requirements
Module: vtx_mem_txn_capture

Interface
REQ-001 SHALL have parameter NUM_TXN, default 4: maximum memory transactions recorded per instruction.
REQ-002 SHALL have port g_clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port g_resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port insn_start  input  1  instruction issued to COP; pulse.
REQ-005 SHALL have port insn_enc  input  32  encoding; sampled with insn_start.
REQ-006 SHALL have port insn_finish  input  1  instruction retired; pulse.
REQ-007 SHALL have ports mem_cen, mem_wen  input  1 each  request strobe and write-enable.
REQ-008 SHALL have port mem_addr, mem_wdata  input  32 each  request address and write data.
REQ-009 SHALL have port mem_ben  input  4  byte enables.
REQ-010 SHALL have port mem_stall  input  1  request not accepted this cycle.
REQ-011 SHALL have ports mem_rdata  input  32 and mem_error  input  1  response; valid the cycle after acceptance.
REQ-012 SHALL have port vtx_valid  output  1  one-cycle pulse, record complete.
REQ-013 SHALL have port vtx_instr_enc  output  32  captured encoding.
REQ-014 SHALL have ports vtx_mem_cen, vtx_mem_wen, vtx_mem_error  output  NUM_TXN each  per-slot flags; bit i = slot i.
REQ-015 SHALL have ports vtx_mem_addr, vtx_mem_wdata, vtx_mem_rdata  output  32*NUM_TXN each; slot i at [32i+31:32i].
REQ-016 SHALL have port vtx_mem_ben  output  4*NUM_TXN; slot i at [4i+3:4i].
REQ-017 SHALL have port vtx_txn_overflow  output  1  sticky: instruction exceeded NUM_TXN transactions.

Function
REQ-018 SHALL implement states IDLE, COLLECT, DRAIN, EMIT.
REQ-019 Transaction acceptance SHALL be mem_cen=1 and mem_stall=0 in the same cycle.
REQ-020 IDLE -> COLLECT on insn_start: clear slot count to 0, clear all per-slot flags, latch insn_enc.
REQ-021 In COLLECT, each acceptance SHALL write addr, wdata, ben, wen into slot[count], set vtx_mem_cen[count], increment count.
REQ-022 rdata and error SHALL be written into the slot accepted the previous cycle.
REQ-023 Accepted request in the same cycle as insn_finish SHALL belong to the current instruction.
REQ-024 COLLECT -> EMIT on insn_finish if no response is pending after this cycle.
REQ-025 COLLECT -> DRAIN on insn_finish if a response is pending after this cycle. DRAIN -> EMIT next cycle, after the response is captured.
REQ-026 In EMIT, vtx_valid SHALL be 1 for exactly one cycle; then -> IDLE. All slot outputs SHALL hold until the next insn_start.
REQ-027 An acceptance with count = NUM_TXN SHALL record nothing, set vtx_txn_overflow, and leave count saturated.
REQ-028 vtx_txn_overflow SHALL clear only on reset.
REQ-029 insn_start and insn_finish in the same cycle from IDLE SHALL give a zero-transaction record: vtx_valid two cycles later, all cen bits 0.
REQ-030 insn_start in EMIT SHALL be honoured: EMIT -> COLLECT with state cleared.
REQ-031 Outside COLLECT/DRAIN, acceptances and insn_finish SHALL be ignored.
REQ-032 insn_start in COLLECT or DRAIN SHALL be ignored.
REQ-033 Latency SHALL be 1 cycle from insn_finish to vtx_valid, or 2 cycles when DRAIN is entered.

Reset
REQ-034 g_resetn=0 SHALL immediately force state IDLE, count 0, and vtx_valid 0.
REQ-035 g_resetn=0 SHALL immediately clear all vtx_* outputs and vtx_txn_overflow to 0, independent of g_clk.
REQ-036 Reset mid-instruction SHALL discard the partial record; no vtx_valid follows deassertion.

Verification
REQ-037 Test: start (enc 0x0000_1234), 2 loads at 0x100 and 0x104 (rdata 0xAA, 0xBB), finish -> vtx_valid once; cen=0011; rdata slots 0xAA/0xBB; enc 0x1234.
REQ-038 Test: store (addr 0x200, wdata 0xDEAD_BEEF, ben 0xF) accepted in the finish cycle -> DRAIN taken; vtx_valid 2 cycles after finish; wen[0]=1; slot0 correct.
REQ-039 Test: mem_cen=1 with mem_stall=1 for 3 cycles, then accepted -> exactly one slot recorded; addr is the final one.
REQ-040 Test: 5 accepted transactions in one instruction -> cen=1111; slot 3 holds the 4th txn; vtx_txn_overflow=1 and stays 1 for the next instruction.
REQ-041 Test: g_resetn low after 2 txns -> outputs 0 immediately; no vtx_valid after release; next instruction records from slot 0.
REQ-042 Test: mem_error=1 on the response for slot 1 -> vtx_mem_error=0010.

Source files
------------

// File: rtl/vtx_mem_txn_capture.sv
// Records up to NUM_TXN memory transactions per coprocessor instruction and emits one record.
// Latency 1 cycle finish->vtx_valid (2 with a trailing response); no backpressure, every transaction is observed.
module vtx_mem_txn_capture #(
    parameter int NUM_TXN = 4
) (
    input  logic                   g_clk,
    input  logic                   g_resetn,
    input  logic                   insn_start,
    input  logic [31:0]            insn_enc,
    input  logic                   insn_finish,
    input  logic                   mem_cen,
    input  logic                   mem_wen,
    input  logic [31:0]            mem_addr,
    input  logic [31:0]            mem_wdata,
    input  logic [3:0]             mem_ben,
    input  logic                   mem_stall,
    input  logic [31:0]            mem_rdata,
    input  logic                   mem_error,
    output logic                   vtx_valid,
    output logic [31:0]            vtx_instr_enc,
    output logic [NUM_TXN-1:0]     vtx_mem_cen,
    output logic [NUM_TXN-1:0]     vtx_mem_wen,
    output logic [NUM_TXN-1:0]     vtx_mem_error,
    output logic [32*NUM_TXN-1:0]  vtx_mem_addr,
    output logic [32*NUM_TXN-1:0]  vtx_mem_wdata,
    output logic [32*NUM_TXN-1:0]  vtx_mem_rdata,
    output logic [4*NUM_TXN-1:0]   vtx_mem_ben,
    output logic                   vtx_txn_overflow
);

    localparam int CW = $clog2(NUM_TXN + 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN,
        EMIT
    } state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [CW-1:0]   resp_slot;
    logic            resp_vld;

    logic            acc;
    logic            acc_collect;
    logic            rec;
    logic            start_ok;

    assign acc         = mem_cen & ~mem_stall;
    assign acc_collect = acc & (state == COLLECT);
    // Only a recorded acceptance owes a response; overflow acceptances are dropped entirely.
    assign rec         = acc_collect & (count < CW'(NUM_TXN));
    assign start_ok    = insn_start & ((state == IDLE) | (state == EMIT));

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state            <= IDLE;
            count            <= '0;
            resp_slot        <= '0;
            resp_vld         <= 1'b0;
            vtx_valid        <= 1'b0;
            vtx_instr_enc    <= '0;
            vtx_mem_cen      <= '0;
            vtx_mem_wen      <= '0;
            vtx_mem_error    <= '0;
            vtx_mem_addr     <= '0;
            vtx_mem_wdata    <= '0;
            vtx_mem_rdata    <= '0;
            vtx_mem_ben      <= '0;
            vtx_txn_overflow <= 1'b0;
        end else begin
            vtx_valid <= 1'b0;
            resp_vld  <= 1'b0;

            for (int i = 0; i < NUM_TXN; i++) begin
                if (resp_vld && resp_slot == CW'(i)) begin
                    vtx_mem_rdata[32*i +: 32] <= mem_rdata;
                    vtx_mem_error[i]          <= mem_error;
                end
                if (rec && count == CW'(i)) begin
                    vtx_mem_addr[32*i +: 32]  <= mem_addr;
                    vtx_mem_wdata[32*i +: 32] <= mem_wdata;
                    vtx_mem_ben[4*i +: 4]     <= mem_ben;
                    vtx_mem_wen[i]            <= mem_wen;
                    vtx_mem_cen[i]            <= 1'b1;
                end
            end

            if (rec) begin
                count     <= count + CW'(1);
                resp_slot <= count;
                resp_vld  <= 1'b1;
            end
            if (acc_collect && !rec) begin
                vtx_txn_overflow <= 1'b1;
            end

            case (state)
                IDLE: begin
                    // start+finish together still needs a cycle to settle, so route via DRAIN
                    if (insn_start) begin
                        state <= insn_finish ? DRAIN : COLLECT;
                    end
                end
                COLLECT: begin
                    if (insn_finish) begin
                        if (rec) begin
                            state <= DRAIN;
                        end else begin
                            state     <= EMIT;
                            vtx_valid <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    state     <= EMIT;
                    vtx_valid <= 1'b1;
                end
                EMIT: begin
                    state <= insn_start ? COLLECT : IDLE;
                end
                default: state <= IDLE;
            endcase

            if (start_ok) begin
                count         <= '0;
                vtx_mem_cen   <= '0;
                vtx_mem_wen   <= '0;
                vtx_mem_error <= '0;
                vtx_instr_enc <= insn_enc;
            end
        end
    end

endmodule

// File: tb/tb_vtx_mem_txn_capture.sv
// Directed bench for vtx_mem_txn_capture: transaction-level model compared every cycle,
// plus literal expectations at each record boundary.
module tb_vtx_mem_txn_capture;

    localparam int N = 4;

    logic            g_clk, g_resetn;
    logic            insn_start, insn_finish;
    logic [31:0]     insn_enc;
    logic            mem_cen, mem_wen, mem_stall, mem_error;
    logic [31:0]     mem_addr, mem_wdata, mem_rdata;
    logic [3:0]      mem_ben;
    logic            vtx_valid, vtx_txn_overflow;
    logic [31:0]     vtx_instr_enc;
    logic [N-1:0]    vtx_mem_cen, vtx_mem_wen, vtx_mem_error;
    logic [32*N-1:0] vtx_mem_addr, vtx_mem_wdata, vtx_mem_rdata;
    logic [4*N-1:0]  vtx_mem_ben;

    vtx_mem_txn_capture #(.NUM_TXN(N)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .insn_start(insn_start), .insn_enc(insn_enc), .insn_finish(insn_finish),
        .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ben(mem_ben), .mem_stall(mem_stall), .mem_rdata(mem_rdata), .mem_error(mem_error),
        .vtx_valid(vtx_valid), .vtx_instr_enc(vtx_instr_enc),
        .vtx_mem_cen(vtx_mem_cen), .vtx_mem_wen(vtx_mem_wen), .vtx_mem_error(vtx_mem_error),
        .vtx_mem_addr(vtx_mem_addr), .vtx_mem_wdata(vtx_mem_wdata), .vtx_mem_rdata(vtx_mem_rdata),
        .vtx_mem_ben(vtx_mem_ben), .vtx_txn_overflow(vtx_txn_overflow)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    int checks = 0;
    int errors = 0;
    int n_valid = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: one record of slots, plus "busy"/"drain" phases of an instruction.
    typedef struct {
        logic        cen, wen, err;
        logic [31:0] addr, wdata, rdata;
        logic [3:0]  ben;
    } slot_t;

    slot_t       ms[N];
    int          m_cnt, m_resp;
    bit          m_busy, m_drain, m_valid, m_ovf;
    logic [31:0] m_enc;
    logic [N-1:0]    e_cen, e_wen, e_err;
    logic [32*N-1:0] e_addr, e_wdata, e_rdata;
    logic [4*N-1:0]  e_ben;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            ms[i].cen = 0; ms[i].wen = 0; ms[i].err = 0;
            ms[i].addr = 0; ms[i].wdata = 0; ms[i].rdata = 0; ms[i].ben = 0;
        end
        m_cnt = 0; m_resp = -1; m_busy = 0; m_drain = 0; m_valid = 0; m_ovf = 0; m_enc = 0;
    endtask

    always @(posedge g_clk) begin
        if (!g_resetn) begin
            model_reset();
        end else begin
            bit accepted, emit_now, may_start;
            int new_resp;
            accepted  = mem_cen && !mem_stall;
            may_start = !m_busy && !m_drain;
            emit_now  = 0;
            new_resp  = -1;
            if (m_resp >= 0) begin
                ms[m_resp].rdata = mem_rdata;
                ms[m_resp].err   = mem_error;
            end
            if (m_drain) begin
                m_drain  = 0;
                emit_now = 1;
            end else if (m_busy) begin
                if (accepted) begin
                    if (m_cnt < N) begin
                        ms[m_cnt].cen = 1; ms[m_cnt].wen = mem_wen;
                        ms[m_cnt].addr = mem_addr; ms[m_cnt].wdata = mem_wdata;
                        ms[m_cnt].ben = mem_ben;
                        new_resp = m_cnt;
                        m_cnt++;
                    end else begin
                        m_ovf = 1;
                    end
                end
                if (insn_finish) begin
                    m_busy = 0;
                    if (new_resp >= 0) m_drain = 1;
                    else emit_now = 1;
                end
            end else if (may_start && insn_start) begin
                m_cnt = 0;
                m_enc = insn_enc;
                for (int i = 0; i < N; i++) begin
                    ms[i].cen = 0; ms[i].wen = 0; ms[i].err = 0;
                end
                if (insn_finish) m_drain = 1;
                else m_busy = 1;
            end
            m_resp  = new_resp;
            m_valid = emit_now;
        end
        #2;
        for (int i = 0; i < N; i++) begin
            e_cen[i] = ms[i].cen; e_wen[i] = ms[i].wen; e_err[i] = ms[i].err;
            e_addr[32*i +: 32] = ms[i].addr; e_wdata[32*i +: 32] = ms[i].wdata;
            e_rdata[32*i +: 32] = ms[i].rdata; e_ben[4*i +: 4] = ms[i].ben;
        end
        if (vtx_valid === 1'b1) n_valid++;
        chk("valid",    128'(vtx_valid),        128'(m_valid));
        chk("enc",      128'(vtx_instr_enc),    128'(m_enc));
        chk("cen",      128'(vtx_mem_cen),      128'(e_cen));
        chk("wen",      128'(vtx_mem_wen),      128'(e_wen));
        chk("error",    128'(vtx_mem_error),    128'(e_err));
        chk("addr",     128'(vtx_mem_addr),     128'(e_addr));
        chk("wdata",    128'(vtx_mem_wdata),    128'(e_wdata));
        chk("rdata",    128'(vtx_mem_rdata),    128'(e_rdata));
        chk("ben",      128'(vtx_mem_ben),      128'(e_ben));
        chk("overflow", 128'(vtx_txn_overflow), 128'(m_ovf));
    end

    task automatic step();
        @(negedge g_clk);
        insn_start = 0; insn_finish = 0; mem_cen = 0; mem_wen = 0;
        mem_stall = 0; mem_error = 0; mem_rdata = 0;
    endtask

    int nv;

    initial begin
        g_resetn = 0; insn_start = 0; insn_finish = 0; insn_enc = 0;
        mem_cen = 0; mem_wen = 0; mem_stall = 0; mem_error = 0;
        mem_addr = 0; mem_wdata = 0; mem_rdata = 0; mem_ben = 0;
        #1;
        chk("rst_valid", 128'(vtx_valid), 128'h0);
        chk("rst_cen",   128'(vtx_mem_cen), 128'h0);
        chk("rst_ovf",   128'(vtx_txn_overflow), 128'h0);
        @(negedge g_clk);
        g_resetn = 1;
        step();

        // two loads, finish without trailing response
        insn_start = 1; insn_enc = 32'h0000_1234; step();
        mem_cen = 1; mem_addr = 32'h100; step();
        mem_rdata = 32'hAA; mem_cen = 1; mem_addr = 32'h104; step();
        mem_rdata = 32'hBB; insn_finish = 1; step();
        chk("t1_valid", 128'(vtx_valid), 128'h1);
        chk("t1_cen",   128'(vtx_mem_cen), 128'h3);
        chk("t1_rd0",   128'(vtx_mem_rdata[31:0]), 128'hAA);
        chk("t1_rd1",   128'(vtx_mem_rdata[63:32]), 128'hBB);
        chk("t1_enc",   128'(vtx_instr_enc), 128'h1234);
        step();
        chk("t1_pulse", 128'(vtx_valid), 128'h0);

        // store accepted with finish -> drain
        insn_start = 1; insn_enc = 32'h2222; step();
        mem_cen = 1; mem_wen = 1; mem_addr = 32'h200; mem_wdata = 32'hDEAD_BEEF;
        mem_ben = 4'hF; insn_finish = 1; step();
        chk("t2_drain", 128'(vtx_valid), 128'h0);
        step();
        chk("t2_valid", 128'(vtx_valid), 128'h1);
        chk("t2_wen",   128'(vtx_mem_wen), 128'h1);
        chk("t2_addr",  128'(vtx_mem_addr[31:0]), 128'h200);
        chk("t2_wdata", 128'(vtx_mem_wdata[31:0]), 128'hDEAD_BEEF);
        chk("t2_ben",   128'(vtx_mem_ben[3:0]), 128'hF);
        step();

        // stalled request
        insn_start = 1; insn_enc = 32'h3333; step();
        for (int k = 0; k < 3; k++) begin
            mem_cen = 1; mem_stall = 1; mem_addr = 32'h300 + 32'(4 * k); step();
        end
        mem_cen = 1; mem_addr = 32'h30C; step();
        mem_rdata = 32'h55; insn_finish = 1; step();
        chk("t3_valid", 128'(vtx_valid), 128'h1);
        chk("t3_cen",   128'(vtx_mem_cen), 128'h1);
        chk("t3_addr",  128'(vtx_mem_addr[31:0]), 128'h30C);
        step();

        // overflow: five accepted
        insn_start = 1; insn_enc = 32'h4444; step();
        for (int k = 0; k < 5; k++) begin
            mem_rdata = 32'h40 + 32'(k); mem_cen = 1;
            mem_addr = 32'h400 + 32'(4 * k); mem_wdata = 32'(k); step();
        end
        mem_rdata = 32'hFF; insn_finish = 1; step();
        chk("t4_valid", 128'(vtx_valid), 128'h1);
        chk("t4_cen",   128'(vtx_mem_cen), 128'hF);
        chk("t4_addr3", 128'(vtx_mem_addr[127:96]), 128'h40C);
        chk("t4_rd3",   128'(vtx_mem_rdata[127:96]), 128'h44);
        chk("t4_ovf",   128'(vtx_txn_overflow), 128'h1);
        step();

        // error on slot 1 response; overflow stays sticky
        insn_start = 1; insn_enc = 32'h6666; step();
        mem_cen = 1; mem_addr = 32'h500; step();
        mem_rdata = 32'h61; mem_cen = 1; mem_addr = 32'h504; step();
        mem_rdata = 32'h62; mem_error = 1; insn_finish = 1; step();
        chk("t6_valid", 128'(vtx_valid), 128'h1);
        chk("t6_err",   128'(vtx_mem_error), 128'h2);
        chk("t6_ovf",   128'(vtx_txn_overflow), 128'h1);
        step();

        // zero-transaction record, then start honoured in EMIT, start ignored in COLLECT
        insn_start = 1; insn_finish = 1; insn_enc = 32'h7777; step();
        chk("t7_early", 128'(vtx_valid), 128'h0);
        step();
        chk("t7_valid", 128'(vtx_valid), 128'h1);
        chk("t7_cen",   128'(vtx_mem_cen), 128'h0);
        insn_start = 1; insn_enc = 32'h8888; step();
        chk("t8_nov",   128'(vtx_valid), 128'h0);
        insn_start = 1; insn_enc = 32'h9999; mem_cen = 1; mem_addr = 32'h800; step();
        mem_rdata = 32'h81; insn_finish = 1; step();
        chk("t8_valid", 128'(vtx_valid), 128'h1);
        chk("t8_enc",   128'(vtx_instr_enc), 128'h8888);
        chk("t8_cen",   128'(vtx_mem_cen), 128'h1);
        step();

        // reset mid-instruction
        insn_start = 1; insn_enc = 32'h5555; step();
        mem_cen = 1; mem_addr = 32'h510; step();
        mem_rdata = 32'h1; mem_cen = 1; mem_addr = 32'h514; step();
        mem_rdata = 32'h2;
        #2 g_resetn = 0;
        #1;
        chk("t5_valid", 128'(vtx_valid), 128'h0);
        chk("t5_cen",   128'(vtx_mem_cen), 128'h0);
        chk("t5_addr",  128'(vtx_mem_addr), 128'h0);
        chk("t5_enc",   128'(vtx_instr_enc), 128'h0);
        chk("t5_ovf",   128'(vtx_txn_overflow), 128'h0);
        nv = n_valid;
        @(negedge g_clk);
        g_resetn = 1; mem_rdata = 0; insn_finish = 1;
        step(); step(); step();
        chk("t5_novalid", 128'(n_valid), 128'(nv));
        insn_start = 1; insn_enc = 32'hAAAA; step();
        mem_cen = 1; mem_addr = 32'h600; step();
        mem_rdata = 32'h3; insn_finish = 1; step();
        chk("t5b_valid", 128'(vtx_valid), 128'h1);
        chk("t5b_cen",   128'(vtx_mem_cen), 128'h1);
        chk("t5b_addr",  128'(vtx_mem_addr[31:0]), 128'h600);
        chk("t5b_rd0",   128'(vtx_mem_rdata[31:0]), 128'h3);
        step(); step();

        chk("valid_total", 128'(n_valid), 128'd8);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
